life_event_ctrl: RTL and testbench

LIFE_EVENT_CTRL -- requirements
Module: life_event_ctrl

---
 rtl/life_event_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_life_event_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/life_event_ctrl.sv
// Purpose : player life/powerup event controller (hit, shield, immunity blink, extra life, game over).
// Latency : input change sampled at frame edge N is visible on the registered outputs after edge N+1.
// Backpressure: none; level inputs, one-frame pulse and level outputs, no handshake.
//
// Ports:
//   frame_clk    frame-rate clock, all state changes on its rising edge
//   Reset        asynchronous active-high reset
//   enemy_hit    level, player overlaps an enemy or projectile
//   pickup_star  level, player overlaps a star (powerup) item
//   pickup_heart level, player overlaps a heart item
//   lose_game    level from the lives counter, game over
//   lose_life    one-frame pulse, decrement lives
//   extralife    one-frame pulse, increment lives (only while powerup is high)
//   powerup      level, powerup active
//   invuln       level, hit immunity window active
//   blink        sprite visibility toggle during immunity
module life_event_ctrl #(
    parameter int INVULN_FRAMES  = 120,
    parameter int POWERUP_FRAMES = 300,
    parameter int BLINK_HALF     = 8
) (
    input  logic frame_clk,
    input  logic Reset,
    input  logic enemy_hit,
    input  logic pickup_star,
    input  logic pickup_heart,
    input  logic lose_game,
    output logic lose_life,
    output logic extralife,
    output logic powerup,
    output logic invuln,
    output logic blink
);

    localparam logic [8:0] INV_LOAD   = 9'(INVULN_FRAMES);
    localparam logic [8:0] PWR_LOAD   = 9'(POWERUP_FRAMES);
    localparam logic [5:0] BLINK_LAST = 6'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        HIT    = 2'd1,
        IMMUNE = 2'd2,
        DEAD   = 2'd3
    } state_t;

    state_t     state_q, state_d;

    // Previous input level and registered rising-edge event per input.
    logic       hit_prev_q, star_prev_q, heart_prev_q;
    logic       hit_ev_q, star_ev_q, heart_ev_q;

    logic [8:0] imm_cnt_q, imm_cnt_d;
    logic [8:0] pwr_cnt_q, pwr_cnt_d;
    logic [5:0] blink_cnt_q, blink_cnt_d;

    logic       lose_life_d, extralife_d, powerup_d, invuln_d, blink_d;
    logic       pwr_active;
    logic       hit_accept;

    // Edge detection. Registering the event (rather than using it
    // combinationally) gives the one-frame input-to-output latency, and the
    // zeroed previous-level registers make an input held high across reset
    // release count as a fresh rising edge.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            hit_prev_q   <= 1'b0;
            star_prev_q  <= 1'b0;
            heart_prev_q <= 1'b0;
            hit_ev_q     <= 1'b0;
            star_ev_q    <= 1'b0;
            heart_ev_q   <= 1'b0;
        end else begin
            hit_prev_q   <= enemy_hit;
            star_prev_q  <= pickup_star;
            heart_prev_q <= pickup_heart;
            hit_ev_q     <= enemy_hit & ~hit_prev_q;
            star_ev_q    <= pickup_star & ~star_prev_q;
            heart_ev_q   <= pickup_heart & ~heart_prev_q;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= NORMAL;
            imm_cnt_q   <= '0;
            pwr_cnt_q   <= '0;
            blink_cnt_q <= '0;
            lose_life   <= 1'b0;
            extralife   <= 1'b0;
            powerup     <= 1'b0;
            invuln      <= 1'b0;
            blink       <= 1'b0;
        end else begin
            state_q     <= state_d;
            imm_cnt_q   <= imm_cnt_d;
            pwr_cnt_q   <= pwr_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            lose_life   <= lose_life_d;
            extralife   <= extralife_d;
            powerup     <= powerup_d;
            invuln      <= invuln_d;
            blink       <= blink_d;
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        state_d     = state_q;
        imm_cnt_d   = imm_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = 1'b0;
        hit_accept  = 1'b0;
        pwr_active  = (pwr_cnt_q != 9'd0);

        case (state_q)
            NORMAL: begin
                // An active powerup acts as a shield: the hit is dropped.
                if (hit_ev_q && !pwr_active) begin
                    hit_accept = 1'b1;
                    state_d    = HIT;
                end
            end
            HIT: begin
                state_d     = IMMUNE;
                imm_cnt_d   = INV_LOAD;
                blink_cnt_d = '0;
            end
            IMMUNE: begin
                // Leaving on the frame the count would hit zero keeps invuln
                // high for exactly INVULN_FRAMES frames.
                if (imm_cnt_q <= 9'd1) begin
                    state_d     = NORMAL;
                    imm_cnt_d   = '0;
                    blink_cnt_d = '0;
                end else begin
                    imm_cnt_d = imm_cnt_q - 9'd1;
                    blink_d   = blink;
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        blink_d     = ~blink;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = DEAD;
            end
        endcase

        // Star reload restarts the full window; otherwise count down and
        // saturate at zero.
        if (star_ev_q) begin
            pwr_cnt_d = PWR_LOAD;
        end else if (pwr_active) begin
            pwr_cnt_d = pwr_cnt_q - 9'd1;
        end else begin
            pwr_cnt_d = pwr_cnt_q;
        end

        // An accepted hit only happens with powerup low, so a heart can never
        // pay out in the same frame as a lost life.
        extralife_d = heart_ev_q && pwr_active && !hit_accept;

        // Game over overrides everything and is sticky until Reset.
        if (lose_game || state_q == DEAD) begin
            state_d     = DEAD;
            imm_cnt_d   = '0;
            pwr_cnt_d   = '0;
            blink_cnt_d = '0;
            blink_d     = 1'b0;
            extralife_d = 1'b0;
        end

        lose_life_d = (state_d == HIT);
        invuln_d    = (state_d == IMMUNE);
        powerup_d   = (pwr_cnt_d != 9'd0);
    end

endmodule

// File: tb/tb_life_event_ctrl.sv
module tb_life_event_ctrl;

    localparam int INV = 120;
    localparam int PWR = 300;
    localparam int BH  = 8;

    logic frame_clk;
    logic Reset;
    logic enemy_hit, pickup_star, pickup_heart, lose_game;
    logic lose_life, extralife, powerup, invuln, blink;

    int tests_run;
    int tests_failed;

    // Reference model: events are delayed one frame, then the hit penalty is
    // tracked as "frames since the life was lost" and the powerup as frames left.
    bit m_prev_h, m_prev_s, m_prev_t;
    bit m_pend_h, m_pend_s, m_pend_t;
    bit m_dead;
    int m_hit_time;
    int m_power;
    bit e_lose, e_xl, e_pow, e_inv, e_blink;

    int n_lose, n_xl, n_pow, n_inv, n_blink;

    life_event_ctrl #(
        .INVULN_FRAMES (INV),
        .POWERUP_FRAMES(PWR),
        .BLINK_HALF    (BH)
    ) dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .enemy_hit   (enemy_hit),
        .pickup_star (pickup_star),
        .pickup_heart(pickup_heart),
        .lose_game   (lose_game),
        .lose_life   (lose_life),
        .extralife   (extralife),
        .powerup     (powerup),
        .invuln      (invuln),
        .blink       (blink)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev_h = 0; m_prev_s = 0; m_prev_t = 0;
        m_pend_h = 0; m_pend_s = 0; m_pend_t = 0;
        m_dead = 0; m_hit_time = -1; m_power = 0;
        e_lose = 0; e_xl = 0; e_pow = 0; e_inv = 0; e_blink = 0;
    endtask

    task automatic model_edge();
        bit ev_h, ev_s, ev_t, pw_before, accepted;
        if (Reset) begin
            model_reset();
            return;
        end
        ev_h = m_pend_h; ev_s = m_pend_s; ev_t = m_pend_t;
        m_pend_h = enemy_hit && !m_prev_h;
        m_pend_s = pickup_star && !m_prev_s;
        m_pend_t = pickup_heart && !m_prev_t;
        m_prev_h = enemy_hit; m_prev_s = pickup_star; m_prev_t = pickup_heart;
        if (m_dead || lose_game) begin
            m_dead = 1; m_hit_time = -1; m_power = 0;
            e_lose = 0; e_xl = 0; e_pow = 0; e_inv = 0; e_blink = 0;
            return;
        end
        pw_before = (m_power > 0);
        accepted  = (m_hit_time < 0) && ev_h && !pw_before;
        if (accepted) m_hit_time = 0;
        else if (m_hit_time >= 0) begin
            m_hit_time++;
            if (m_hit_time > INV) m_hit_time = -1;
        end
        if (ev_s) m_power = PWR;
        else if (m_power > 0) m_power--;
        e_lose  = (m_hit_time == 0);
        e_inv   = (m_hit_time >= 1) && (m_hit_time <= INV);
        e_blink = e_inv && ((((m_hit_time - 1) / BH) % 2) == 1);
        e_pow   = (m_power > 0);
        e_xl    = ev_t && pw_before && !accepted;
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".lose_life"}, int'(lose_life), int'(e_lose));
        check({tag, ".extralife"}, int'(extralife), int'(e_xl));
        check({tag, ".powerup"},   int'(powerup),   int'(e_pow));
        check({tag, ".invuln"},    int'(invuln),    int'(e_inv));
        check({tag, ".blink"},     int'(blink),     int'(e_blink));
        check({tag, ".exclusive"}, int'(lose_life & extralife), 0);
        n_lose  += int'(lose_life);
        n_xl    += int'(extralife);
        n_pow   += int'(powerup);
        n_inv   += int'(invuln);
        n_blink += int'(blink);
    endtask

    task automatic clear_counts();
        n_lose = 0; n_xl = 0; n_pow = 0; n_inv = 0; n_blink = 0;
    endtask

    // One frame: the model sees the same inputs the DUT samples, outputs are
    // compared 1 time unit after the edge; callers then change inputs.
    task automatic step(input string tag);
        @(posedge frame_clk);
        model_edge();
        #1;
        check_outs(tag);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset(input string tag);
        #2 Reset = 1'b1;
        model_reset();
        #1 check_outs({tag, ".async"});
        #2 Reset = 1'b0;
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        enemy_hit = 0; pickup_star = 0; pickup_heart = 0; lose_game = 0;
        Reset = 1'b1;
        model_reset();
        clear_counts();
        #1 check_outs("reset");
        run("reset_hold", 2);
        Reset = 1'b0;
        run("idle", 3);

        // Sustained hit: one lose_life, 120 immune frames, blink period 8.
        clear_counts();
        enemy_hit = 1; run("hit_hold", 10); enemy_hit = 0;
        run("immune", 130);
        check("s031.lose_count", n_lose, 1);
        check("s031.invuln_frames", n_inv, 120);
        check("s031.blink_frames", n_blink, 56);

        // Re-hit during immunity is ignored; after it ends it counts.
        pulse_reset("s032");
        clear_counts();
        enemy_hit = 1; step("s032"); enemy_hit = 0;
        run("s032", 60);
        enemy_hit = 1; step("s032"); enemy_hit = 0;
        run("s032", 70);
        check("s032.lose_after_rehit", n_lose, 1);
        enemy_hit = 1; step("s032"); enemy_hit = 0;
        run("s032", 3);
        check("s032.lose_after_window", n_lose, 2);

        // Star then heart pays out; heart after expiry does not.
        pulse_reset("s033");
        clear_counts();
        pickup_star = 1; step("s033"); pickup_star = 0;
        run("s033", 4);
        pickup_heart = 1; step("s033"); pickup_heart = 0;
        run("s033", 3);
        check("s033.extralife_once", n_xl, 1);
        run("s033", 300);
        pickup_heart = 1; step("s033"); pickup_heart = 0;
        run("s033", 3);
        check("s033.no_late_extralife", n_xl, 1);
        check("s033.powerup_expired", int'(powerup), 0);

        // Shield and star reload.
        pulse_reset("s034");
        clear_counts();
        pickup_star = 1; step("s034"); pickup_star = 0;
        run("s034", 99);
        enemy_hit = 1; step("s034"); enemy_hit = 0;
        run("s034", 5);
        check("s034.shield_lose", n_lose, 0);
        check("s034.shield_invuln", n_inv, 0);
        run("s034", 144);
        pickup_star = 1; step("s034"); pickup_star = 0;
        clear_counts();
        run("s034", 320);
        check("s034.reload_frames", n_pow, 300);

        // Hit + heart together with powerup low, then game over.
        pulse_reset("s035");
        clear_counts();
        enemy_hit = 1; pickup_heart = 1; step("s035");
        enemy_hit = 0; pickup_heart = 0;
        run("s035", 5);
        check("s035.lose_only", n_lose, 1);
        check("s035.no_extralife", n_xl, 0);
        lose_game = 1; step("s035_dead");
        check("s035.dead_invuln", int'(invuln), 0);
        lose_game = 0;
        clear_counts();
        for (int i = 0; i < 4; i++) begin
            enemy_hit = 1; pickup_star = 1; step("s035_dead");
            enemy_hit = 0; pickup_star = 0; run("s035_dead", 4);
        end
        check("s035.dead_lose", n_lose, 0);
        check("s035.dead_pow", n_pow, 0);
        check("s035.dead_inv", n_inv, 0);

        // Reset mid-immunity, with the hit input held across release.
        pulse_reset("s036");
        clear_counts();
        enemy_hit = 1; step("s036"); enemy_hit = 0;
        run("s036", 41);
        check("s036.pre_reset_invuln", int'(invuln), 1);
        enemy_hit = 1;
        pulse_reset("s036");
        check("s036.reset_invuln", int'(invuln), 0);
        check("s036.reset_blink", int'(blink), 0);
        clear_counts();
        run("s036", 4);
        enemy_hit = 0;
        check("s036.lose_after_reset", n_lose, 1);

        // Randomized traffic against the model.
        pulse_reset("rnd");
        for (int f = 0; f < 3000; f++) begin
            if ($urandom_range(15) == 0) enemy_hit = ~enemy_hit;
            if ($urandom_range(40) == 0) pickup_star = ~pickup_star;
            if ($urandom_range(12) == 0) pickup_heart = ~pickup_heart;
            lose_game = ($urandom_range(1499) == 0);
            step("rnd");
            if ((m_dead && $urandom_range(49) == 0) || $urandom_range(399) == 0)
                pulse_reset("rnd");
        end
        lose_game = 0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
